// File: rtl/div_sched_pkg.sv
// Shared definitions for the divide scheduler: FSM encodings and result constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // LO value written when the divisor is zero (quotient saturates to all ones)
    localparam logic [31:0] DZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sched.sv
// Sequences the iterative divider for DIV/DIVU in E and produces a one-cycle HI/LO write.
// Latency: stall = 1 launch cycle + N busy cycles up to ready; write strobe one cycle after ready.
// Backpressure: stall_o freezes F/D/E while a divide is launching or in flight; the watchdog aborts after TIMEOUT busy cycles.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6     // 2**CNT_W must exceed TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        flush_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic        div_annul_o,
    output logic [31:0] div_opa_o,
    output logic [31:0] div_opb_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             launch;
    logic             div_zero;
    logic             timeout_hit;

    // A flushed instruction in E never starts anything, including the divide-by-zero shortcut
    assign launch      = start_i & ~flush_i & (opb_i != 32'd0);
    assign div_zero    = start_i & ~flush_i & (opb_i == 32'd0);
    // cnt counts completed busy cycles, so this marks the TIMEOUT-th busy cycle
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: flush beats ready, ready beats the watchdog on the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = BUSY;
                end else if (div_zero) begin
                    state_nxt = DONE;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (div_ready_i) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: stall covers the launch cycle and every busy cycle, released in DONE
    always_comb begin
        stall_o     = 1'b0;
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        hilo_we_o   = 1'b0;
        timeout_o   = 1'b0;
        case (state)
            IDLE: begin
                stall_o = launch | div_zero;
            end
            BUSY: begin
                stall_o     = 1'b1;
                div_start_o = 1'b1;
                div_annul_o = flush_i | (~div_ready_i & timeout_hit);
                timeout_o   = ~flush_i & ~div_ready_i & timeout_hit;
            end
            DONE: begin
                hilo_we_o = ~flush_i;
            end
            default: ;
        endcase
    end

    // Operand latch and busy counter; divider sees only latched operands so forwarding churn is harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            div_opa_o    <= 32'd0;
            div_opb_o    <= 32'd0;
            div_signed_o <= 1'b0;
        end else if (state == IDLE && launch) begin
            cnt          <= '0;
            div_opa_o    <= opa_i;
            div_opb_o    <= opb_i;
            div_signed_o <= signed_i;
        end else if (state == BUSY) begin
            cnt          <= cnt + CNT_W'(1);
        end
    end

    // Result capture: divider result on ready, or the fixed divide-by-zero result; held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_o <= 32'd0;
            lo_o <= 32'd0;
        end else if (state == IDLE && !launch && div_zero) begin
            hi_o <= opa_i;
            lo_o <= DZ_LO;
        end else if (state == BUSY && !flush_i && div_ready_i) begin
            hi_o <= div_result_i[63:32];
            lo_o <= div_result_i[31:0];
        end
    end

endmodule

// File: tb/tb_div_sched.sv
module tb_div_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, flush_i;
    logic [31:0] opa_i, opb_i;
    logic        div_start_o, div_signed_o, div_annul_o;
    logic [31:0] div_opa_o, div_opb_o;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        stall_o, hilo_we_o, timeout_o;
    logic [31:0] hi_o, lo_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_sched #(.TIMEOUT(40), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .start_i(start_i), .signed_i(signed_i), .flush_i(flush_i),
        .opa_i(opa_i), .opb_i(opb_i),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_annul_o(div_annul_o),
        .div_opa_o(div_opa_o), .div_opb_o(div_opb_o),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i),
        .stall_o(stall_o), .hilo_we_o(hilo_we_o),
        .hi_o(hi_o), .lo_o(lo_o), .timeout_o(timeout_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, then wait to the falling edge to sample
    task automatic drive(input logic st, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic rdy, input logic [63:0] res, input logic fl);
        @(posedge clk);
        #1;
        start_i = st; signed_i = sg; opa_i = a; opb_i = b;
        div_ready_i = rdy; div_result_i = res; flush_i = fl;
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] opa, opb;
        logic [63:0] res;        // stub divider result offered on the ready cycle
        int          ready_at;   // cycle index (0 = launch) where the stub asserts ready, 0 = never
        int          flush_at;   // cycle index of a one-cycle flush, 0 = none
        int          e_stall, e_dstart, e_we, e_annul, e_to;
        logic [31:0] e_hi, e_lo;
    } vec_t;

    vec_t vt[9];

    task automatic run_vec(input vec_t v);
        int          c = 0;
        bit          done = 0;
        logic        prev_stall = 1'b0, prev_annul = 1'b0;
        int          n_stall = 0, n_dstart = 0, n_we = 0, n_annul = 0, n_to = 0, n_opmis = 0;
        logic [31:0] got_hi = '0, got_lo = '0;
        logic        rdy;
        while (!done && c < 80) begin
            rdy = (v.ready_at != 0) && (c == v.ready_at);
            // The instruction stays in E while stalled and in the DONE cycle; an aborted one is gone.
            // Operand buses carry junk after launch to prove the latch is used.
            drive((c == 0) || (prev_stall && !prev_annul), v.sgn,
                  (c == 0) ? v.opa : $urandom, (c == 0) ? v.opb : $urandom,
                  rdy, rdy ? v.res : {$urandom, $urandom},
                  (v.flush_at != 0) && (c == v.flush_at));
            n_stall  += int'(stall_o);
            n_dstart += int'(div_start_o);
            n_annul  += int'(div_annul_o);
            n_to     += int'(timeout_o);
            if (hilo_we_o) begin
                n_we++;
                got_hi = hi_o;
                got_lo = lo_o;
            end
            if (div_start_o && (div_opa_o !== v.opa || div_opb_o !== v.opb || div_signed_o !== v.sgn))
                n_opmis++;
            if (c > 0 && !stall_o) done = 1;
            prev_stall = stall_o;
            prev_annul = div_annul_o;
            c++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_bound stall never released within 80 cycles", v.name);
        end
        // Quiet cycle: nothing may fire once the op has retired
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0, 1'b0);
        n_stall  += int'(stall_o);
        n_dstart += int'(div_start_o);
        n_we     += int'(hilo_we_o);
        check({v.name, "_stall"},  64'(n_stall),  64'(v.e_stall));
        check({v.name, "_dstart"}, 64'(n_dstart), 64'(v.e_dstart));
        check({v.name, "_we"},     64'(n_we),     64'(v.e_we));
        check({v.name, "_annul"},  64'(n_annul),  64'(v.e_annul));
        check({v.name, "_tmo"},    64'(n_to),     64'(v.e_to));
        check({v.name, "_oplatch"}, 64'(n_opmis), 64'd0);
        if (v.e_we != 0) check({v.name, "_hilo"}, {got_hi, got_lo}, {v.e_hi, v.e_lo});
    endtask

    initial begin
        //        name        sgn   opa            opb            res                            rdy flush stall dst we an to  hi             lo
        vt[0] = '{"divu",     1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},               33, 0,    34,  33, 1, 0, 0, 32'd2,         32'd14};
        vt[1] = '{"div_neg",  1'b1, 32'hFFFFFF9C,  32'd7,         {32'hFFFFFFFE, 32'hFFFFFFF2},  33, 0,    34,  33, 1, 0, 0, 32'hFFFFFFFE,  32'hFFFFFFF2};
        vt[2] = '{"divzero",  1'b0, 32'h1234,      32'd0,         64'd0,                          0, 0,     1,   0, 1, 0, 0, 32'h1234,      32'hFFFFFFFF};
        vt[3] = '{"fast",     1'b0, 32'd9,         32'd4,         {32'd1, 32'd2},                 1, 0,     2,   1, 1, 0, 0, 32'd1,         32'd2};
        vt[4] = '{"rdy_edge", 1'b0, 32'd50,        32'd6,         {32'd2, 32'd8},                40, 0,    41,  40, 1, 0, 0, 32'd2,         32'd8};
        vt[5] = '{"fl_rdy",   1'b1, 32'd20,        32'd3,         {32'd2, 32'd6},                 5, 5,     6,   5, 0, 1, 0, 32'd0,         32'd0};
        vt[6] = '{"fl_done",  1'b0, 32'd30,        32'd4,         {32'd2, 32'd7},                33, 34,   34,  33, 0, 0, 0, 32'd0,         32'd0};
        vt[7] = '{"big",      1'b0, 32'hFFFFFFFF,  32'h10,        {32'hF, 32'h0FFFFFFF},         34, 0,    35,  34, 1, 0, 0, 32'hF,         32'h0FFFFFFF};
        vt[8] = '{"flush10",  1'b0, 32'd77,        32'd5,         {32'd2, 32'd15},               33, 10,   11,  10, 0, 1, 0, 32'd0,         32'd0};

        rst = 1'b1;
        start_i = 0; signed_i = 0; flush_i = 0; opa_i = 0; opb_i = 0;
        div_ready_i = 0; div_result_i = '0;
        #12;
        check("reset_strobes", {59'd0, stall_o, div_start_o, div_annul_o, hilo_we_o, timeout_o}, 64'd0);
        check("reset_data", {hi_o, lo_o} | {div_opa_o, div_opb_o} | 64'(div_signed_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        // Flush aborts never touch HI/LO: the last captured result ("big") is still presented
        check("hold_hilo", {hi_o, lo_o}, {32'hF, 32'h0FFFFFFF});

        // Watchdog: stub never answers, abort on the 40th busy cycle
        run_vec('{"timeout", 1'b0, 32'd123, 32'd11, 64'd0, 0, 0, 41, 40, 0, 1, 1, 32'd0, 32'd0});

        // Back-to-back: second DIV launches in the IDLE cycle right after DONE
        drive(1, 0, 32'd50, 32'd5, 0, 64'd0, 0);
        check("b2b_launch1_stall", 64'(stall_o), 64'd1);
        drive(1, 0, 32'd0, 32'd0, 0, 64'd0, 0);
        drive(1, 0, 32'd0, 32'd0, 1, {32'd0, 32'd10}, 0);
        drive(1, 0, 32'd0, 32'd0, 0, 64'd0, 0);
        check("b2b_done1", {62'd0, hilo_we_o, stall_o}, 64'd2);
        check("b2b_lo1", 64'(lo_o), 64'd10);
        drive(1, 1, 32'd9, 32'd3, 0, 64'd0, 0);
        check("b2b_launch2_stall", 64'(stall_o), 64'd1);
        drive(1, 0, 32'd0, 32'd0, 1, {32'd0, 32'd3}, 0);
        check("b2b_busy2", {div_start_o, div_signed_o, div_opa_o}, {1'b1, 1'b1, 32'd9});
        drive(1, 0, 32'd0, 32'd0, 0, 64'd0, 0);
        check("b2b_done2", {hilo_we_o, hi_o, lo_o}, {1'b1, 32'd0, 32'd3});
        drive(0, 0, 32'd0, 32'd0, 0, 64'd0, 0);

        // Asynchronous reset in the middle of BUSY
        drive(1, 1, 32'd77, 32'd3, 0, 64'd0, 0);
        drive(1, 0, 32'd0, 32'd0, 0, 64'd0, 0);
        drive(1, 0, 32'd0, 32'd0, 0, 64'd0, 0);
        check("pre_rst_busy", 64'(div_start_o), 64'd1);
        #2;
        rst = 1'b1;
        start_i = 1'b0;
        #1;
        check("async_rst_strobes", {59'd0, stall_o, div_start_o, div_annul_o, hilo_we_o, timeout_o}, 64'd0);
        check("async_rst_data", {div_opa_o, hi_o | lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 32'd0, 32'd0, 0, 64'd0, 0);
        check("post_rst_idle", {62'd0, stall_o, div_start_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
